// File: rtl/fpnew_aux_sink.sv
// Tail of the FPNew aux chain: buffers tag/aux plus lane result/status in a small
// FIFO so consumer stalls never reach the lane chain combinationally.
module fpnew_aux_sink #(
    parameter int unsigned Depth     = 2,
    parameter type         TagType   = logic,
    parameter type         AuxType   = logic,
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  TagType               tag_i,
    input  AuxType               aux_i,
    input  logic [DataWidth-1:0] result_i,
    input  logic [4:0]           status_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output TagType               tag_o,
    output AuxType               aux_o,
    output logic [DataWidth-1:0] result_o,
    output logic [4:0]           status_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);

    localparam int unsigned     CntW     = $clog2(Depth + 1);
    localparam int unsigned     PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    TagType               tag_mem_r    [Depth];
    AuxType               aux_mem_r    [Depth];
    logic [DataWidth-1:0] result_mem_r [Depth];
    logic [4:0]           status_mem_r [Depth];

    logic [PtrW-1:0] wr_ptr_r;
    logic [PtrW-1:0] rd_ptr_r;
    logic [CntW-1:0] count_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;

    // Pointers wrap explicitly so non-power-of-2 depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == LastPtr) begin
            nxt = {PtrW{1'b0}};
        end else begin
            nxt = ptr + PtrW'(1'b1);
        end
        return nxt;
    endfunction

    // Occupancy flags derive from the count register only; ready never sees out_ready_i.
    always_comb begin
        full_s  = (count_r == DepthCnt);
        empty_s = (count_r == {CntW{1'b0}});
        push_s  = in_valid_i & ~full_s;
        pop_s   = ~empty_s & out_ready_i;
    end

    // Head entry and occupancy status presented to both neighbours.
    always_comb begin
        in_ready_o  = ~full_s;
        out_valid_o = ~empty_s;
        busy_o      = ~empty_s;
        tag_o       = tag_mem_r[rd_ptr_r];
        aux_o       = aux_mem_r[rd_ptr_r];
        result_o    = result_mem_r[rd_ptr_r];
        status_o    = status_mem_r[rd_ptr_r];
    end

    // FIFO state: reset beats flush, and flush discards a same-cycle push and pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
            for (int unsigned i = 0; i < Depth; i++) begin
                tag_mem_r[i]    <= '0;
                aux_mem_r[i]    <= '0;
                result_mem_r[i] <= {DataWidth{1'b0}};
                status_mem_r[i] <= 5'b00000;
            end
        end else if (flush_i) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r]    <= tag_i;
                aux_mem_r[wr_ptr_r]    <= aux_i;
                result_mem_r[wr_ptr_r] <= result_i;
                status_mem_r[wr_ptr_r] <= status_i;
                wr_ptr_r               <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CntW'(1'b1);
                2'b01:   count_r <= count_r - CntW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fpnew_aux_sink.sv
// Scoreboard bench: two sinks (depth 2 and 3) share one stimulus stream; each has
// an ordered queue of expected entries checked by its own output monitor.
module tb_fpnew_aux_sink;

    typedef logic [7:0]  tag_t;
    typedef logic [3:0]  aux_t;
    typedef logic [80:0] item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    tag_t        tag_in = 8'h00;
    aux_t        aux_in = 4'h0;
    logic [63:0] res_in = 64'h0;
    logic [4:0]  st_in = 5'h00;

    logic        rdy2, vld2, busy2, rdy3, vld3, busy3;
    tag_t        tag2, tag3;
    aux_t        aux2, aux3;
    logic [63:0] res2, res3;
    logic [4:0]  st2, st3;

    item_t q2[$];
    item_t q3[$];
    logic  pend2 = 1'b0;
    logic  pend3 = 1'b0;
    item_t pend_item = '0;
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    fpnew_aux_sink #(.Depth(2), .TagType(tag_t), .AuxType(aux_t), .DataWidth(64)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .tag_i(tag_in), .aux_i(aux_in), .result_i(res_in),
        .status_i(st_in), .in_valid_i(in_valid), .in_ready_o(rdy2), .flush_i(flush),
        .tag_o(tag2), .aux_o(aux2), .result_o(res2), .status_o(st2),
        .out_valid_o(vld2), .out_ready_i(out_ready), .busy_o(busy2)
    );

    fpnew_aux_sink #(.Depth(3), .TagType(tag_t), .AuxType(aux_t), .DataWidth(64)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .tag_i(tag_in), .aux_i(aux_in), .result_i(res_in),
        .status_i(st_in), .in_valid_i(in_valid), .in_ready_o(rdy3), .flush_i(flush),
        .tag_o(tag3), .aux_o(aux3), .result_o(res3), .status_o(st3),
        .out_valid_o(vld3), .out_ready_i(out_ready), .busy_o(busy3)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: commit the previous cycle's accepted push to the models, check
    // occupancy flags against the models, then drive the next stimulus.
    task automatic step(input logic r, input logic f, input logic v, input logic o, input tag_t t);
        @(posedge clk);
        if (rst || flush) begin
            q2.delete();
            q3.delete();
        end else begin
            if (pend2) q2.push_back(pend_item);
            if (pend3) q3.push_back(pend_item);
        end
        #1;
        chk("ready2", rdy2, q2.size() < 2);
        chk("valid2", vld2, q2.size() != 0);
        chk("busy2",  busy2, q2.size() != 0);
        chk("ready3", rdy3, q3.size() < 3);
        chk("valid3", vld3, q3.size() != 0);
        chk("busy3",  busy3, q3.size() != 0);
        rst       = r;
        flush     = f;
        in_valid  = v;
        out_ready = o;
        tag_in    = t;
        aux_in    = 4'($urandom);
        res_in    = {$urandom, $urandom};
        st_in     = 5'($urandom);
        pend_item = {tag_in, aux_in, res_in, st_in};
        pend2     = v && !r && !f && (q2.size() < 2);
        pend3     = v && !r && !f && (q3.size() < 3);
    endtask

    // Depth-2 monitor: the head must match the oldest expected entry; a handshake consumes it.
    always @(negedge clk) begin
        if (vld2 === 1'b1) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head2: got tag %0h expected no valid entry", tag2);
            end else begin
                chk("head2", {tag2, aux2, res2, st2}, q2[0]);
                if (out_ready) q2.delete(0);
            end
        end
    end

    // Depth-3 monitor, same rule.
    always @(negedge clk) begin
        if (vld3 === 1'b1) begin
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head3: got tag %0h expected no valid entry", tag3);
            end else begin
                chk("head3", {tag3, aux3, res3, st3}, q3[0]);
                if (out_ready) q3.delete(0);
            end
        end
    end

    initial begin
        // Reset, then idle: cleared storage shows as zero data.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset_data2", {tag2, aux2, res2, st2}, 81'd0);
        chk("reset_data3", {tag3, aux3, res3, st3}, 81'd0);

        // Fill depth-2 with tags 1,2 while stalled, hold, then drain in order.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Full depth-2 with pop and push offered together: pop only, push next cycle.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd6);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Two entries buffered, flush with a simultaneous push of tag 7.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd10);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd11);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd7);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Reset with two entries stalled, then tag 5 must be the first output.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd12);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd13);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Continuous streaming of tags 0..9: one per cycle, pointers wrap.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1, tag_t'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), tag_t'($urandom));
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("drained2", q2.size(), 0);
        chk("drained3", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
